// File: rtl/trace_pkg.sv
// Shared types for the commit-trace checker: record kinds, golden record layout, checker state.
package trace_pkg;

  localparam int unsigned KIND_W = 3;
  localparam int unsigned PC_W   = 16;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned DATA_W = 16;

  typedef logic [KIND_W-1:0] kind_t;

  localparam kind_t KIND_REG  = 3'd0;
  localparam kind_t KIND_LD   = 3'd1;
  localparam kind_t KIND_STU  = 3'd2;
  localparam kind_t KIND_ST   = 3'd3;
  localparam kind_t KIND_NOP  = 3'd4;
  localparam kind_t KIND_HALT = 3'd5;

  // Golden record; 70 bits. 'rd' holds the expected destination register.
  typedef struct packed {
    kind_t             kind;
    logic [PC_W-1:0]   pc;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rval;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] mval;
  } exp_rec_t;

  localparam int unsigned EXP_REC_W = $bits(exp_rec_t);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DONE = 2'd1,
    FAIL = 2'd2
  } state_t;

  // Same priority the trace writer uses when it labels a retired instruction.
  function automatic kind_t classify(input logic regwrite, input logic memread,
                                     input logic memwrite, input logic halt);
    kind_t k;
    if (regwrite && memwrite)     k = KIND_STU;
    else if (regwrite && memread) k = KIND_LD;
    else if (regwrite)            k = KIND_REG;
    else if (halt)                k = KIND_HALT;
    else if (memwrite)            k = KIND_ST;
    else                          k = KIND_NOP;
    return k;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push is refused when full, pop when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH_W = $clog2(DEPTH);
  localparam int unsigned PTR_W   = DEPTH_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Status: equal pointers mean empty; equal index with differing wrap bit means full.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[DEPTH_W-1:0] == rd_ptr_q[DEPTH_W-1:0]) &&
            (wr_ptr_q[DEPTH_W] != rd_ptr_q[DEPTH_W]);
    rdata = mem_q[rd_ptr_q[DEPTH_W-1:0]];
  end

  // Pointer advance for accepted push/pop.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/commit_trace_checker.sv
// Compares retired-instruction commit events against buffered golden trace records.
module commit_trace_checker
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CNT_W       = 32,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_valid,
  input  logic [15:0]      c_pc,
  input  logic             c_regwrite,
  input  logic [2:0]       c_wreg,
  input  logic [15:0]      c_wdata,
  input  logic             c_memread,
  input  logic             c_memwrite,
  input  logic [15:0]      c_maddr,
  input  logic [15:0]      c_mdata,
  input  logic             c_halt,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [2:0]       exp_kind,
  input  logic [15:0]      exp_pc,
  input  logic [2:0]       exp_reg,
  input  logic [15:0]      exp_rval,
  input  logic [15:0]      exp_addr,
  input  logic [15:0]      exp_mval,
  output logic             mismatch,
  output logic             underrun,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_inum,
  output logic             done,
  output logic             pass
);

  exp_rec_t   push_rec, head_rec;
  logic       fifo_full, fifo_empty;
  logic       push, pop;

  state_t     state_q, state_d;
  logic       ready_en_q, ready_en_d;
  logic       mismatch_q, mismatch_d;
  logic       underrun_q, underrun_d;
  logic [CNT_W-1:0] inst_count_q, inst_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] first_err_q, first_err_d;

  kind_t      c_kind;
  logic       commit_run, fld_err, cmp_err;

  assign push_rec = '{kind: exp_kind, pc: exp_pc, rd: exp_reg,
                      rval: exp_rval, addr: exp_addr, mval: exp_mval};

  sync_fifo #(
    .WIDTH (EXP_REC_W),
    .DEPTH (DEPTH)
  ) u_exp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_rec),
    .pop   (pop),
    .rdata (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Classify the commit and compare only the fields its kind carries.
  always_comb begin
    c_kind  = classify(c_regwrite, c_memread, c_memwrite, c_halt);
    fld_err = (head_rec.kind != c_kind) || (head_rec.pc != c_pc);
    case (c_kind)
      KIND_REG: fld_err = fld_err || (head_rec.rd != c_wreg) || (head_rec.rval != c_wdata);
      KIND_LD:  fld_err = fld_err || (head_rec.rd != c_wreg) || (head_rec.rval != c_wdata) ||
                          (head_rec.addr != c_maddr);
      KIND_STU: fld_err = fld_err || (head_rec.rd != c_wreg) || (head_rec.rval != c_wdata) ||
                          (head_rec.addr != c_maddr) || (head_rec.mval != c_mdata);
      KIND_ST:  fld_err = fld_err || (head_rec.addr != c_maddr) || (head_rec.mval != c_mdata);
      default:  ;
    endcase
    commit_run = commit_valid & (state_q == RUN);
    // An empty FIFO is an underrun even if a record is being pushed this cycle.
    cmp_err    = commit_run & (fifo_empty | fld_err);
    pop        = commit_run & ~fifo_empty;
    push       = exp_valid & exp_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Next state: a stopping mismatch wins over HALT so done stays low.
  always_comb begin
    state_d = state_q;
    if (commit_run) begin
      if (cmp_err && STOP_ON_ERR)  state_d = FAIL;
      else if (c_kind == KIND_HALT) state_d = DONE;
    end
  end

  // FSM outputs; exp_ready is held low until the first clock after reset release.
  always_comb begin
    exp_ready = ready_en_q & ~fifo_full & (state_q == RUN);
    done      = (state_q == DONE);
    pass      = done & (err_count_q == '0) & ~underrun_q;
  end

  // Counter, flag and first-error capture updates.
  always_comb begin
    ready_en_d   = 1'b1;
    mismatch_d   = cmp_err;
    underrun_d   = underrun_q | (commit_run & fifo_empty);
    inst_count_d = inst_count_q;
    err_count_d  = err_count_q;
    first_err_d  = first_err_q;
    if (commit_run) inst_count_d = inst_count_q + CNT_W'(1);
    if (cmp_err) begin
      if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
      if (err_count_q == '0) first_err_d = inst_count_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_q   <= 1'b0;
      mismatch_q   <= 1'b0;
      underrun_q   <= 1'b0;
      inst_count_q <= '0;
      err_count_q  <= '0;
      first_err_q  <= '0;
    end else begin
      ready_en_q   <= ready_en_d;
      mismatch_q   <= mismatch_d;
      underrun_q   <= underrun_d;
      inst_count_q <= inst_count_d;
      err_count_q  <= err_count_d;
      first_err_q  <= first_err_d;
    end
  end

  assign mismatch       = mismatch_q;
  assign underrun       = underrun_q;
  assign inst_count     = inst_count_q;
  assign err_count      = err_count_q;
  assign first_err_inum = first_err_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench: one checker stops on first error, a second keeps checking.
module tb_commit_trace_checker;

  logic        clk, rst;
  logic        commit_valid, c_regwrite, c_memread, c_memwrite, c_halt;
  logic [15:0] c_pc, c_wdata, c_maddr, c_mdata;
  logic [2:0]  c_wreg;
  logic        exp_valid;
  logic [2:0]  exp_kind, exp_reg;
  logic [15:0] exp_pc, exp_rval, exp_addr, exp_mval;

  logic        exp_ready, mismatch, underrun, done, pass;
  logic [31:0] inst_count, err_count, first_err_inum;
  logic        exp_ready_n, mismatch_n, underrun_n, done_n, pass_n;
  logic [31:0] inst_count_n, err_count_n, first_err_inum_n;

  int checks = 0;
  int errors = 0;

  commit_trace_checker #(.DEPTH(4), .CNT_W(32), .STOP_ON_ERR(1'b1)) dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .c_pc(c_pc),
    .c_regwrite(c_regwrite), .c_wreg(c_wreg), .c_wdata(c_wdata),
    .c_memread(c_memread), .c_memwrite(c_memwrite), .c_maddr(c_maddr),
    .c_mdata(c_mdata), .c_halt(c_halt), .exp_valid(exp_valid),
    .exp_ready(exp_ready), .exp_kind(exp_kind), .exp_pc(exp_pc),
    .exp_reg(exp_reg), .exp_rval(exp_rval), .exp_addr(exp_addr),
    .exp_mval(exp_mval), .mismatch(mismatch), .underrun(underrun),
    .inst_count(inst_count), .err_count(err_count),
    .first_err_inum(first_err_inum), .done(done), .pass(pass));

  commit_trace_checker #(.DEPTH(4), .CNT_W(32), .STOP_ON_ERR(1'b0)) dut_n (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .c_pc(c_pc),
    .c_regwrite(c_regwrite), .c_wreg(c_wreg), .c_wdata(c_wdata),
    .c_memread(c_memread), .c_memwrite(c_memwrite), .c_maddr(c_maddr),
    .c_mdata(c_mdata), .c_halt(c_halt), .exp_valid(exp_valid),
    .exp_ready(exp_ready_n), .exp_kind(exp_kind), .exp_pc(exp_pc),
    .exp_reg(exp_reg), .exp_rval(exp_rval), .exp_addr(exp_addr),
    .exp_mval(exp_mval), .mismatch(mismatch_n), .underrun(underrun_n),
    .inst_count(inst_count_n), .err_count(err_count_n),
    .first_err_inum(first_err_inum_n), .done(done_n), .pass(pass_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    commit_valid = 1'b0; c_pc = '0; c_regwrite = 1'b0; c_wreg = '0; c_wdata = '0;
    c_memread = 1'b0; c_memwrite = 1'b0; c_maddr = '0; c_mdata = '0; c_halt = 1'b0;
    exp_valid = 1'b0; exp_kind = '0; exp_pc = '0; exp_reg = '0;
    exp_rval = '0; exp_addr = '0; exp_mval = '0;
  endtask

  task automatic put_exp(input logic [2:0] k, input logic [15:0] pc, input logic [2:0] rd,
                         input logic [15:0] rval, input logic [15:0] addr, input logic [15:0] mval);
    exp_valid = 1'b1; exp_kind = k; exp_pc = pc; exp_reg = rd;
    exp_rval = rval; exp_addr = addr; exp_mval = mval;
  endtask

  task automatic push_one(input logic [2:0] k, input logic [15:0] pc, input logic [2:0] rd,
                          input logic [15:0] rval, input logic [15:0] addr, input logic [15:0] mval);
    put_exp(k, pc, rd, rval, addr, mval);
    @(negedge clk);
    exp_valid = 1'b0;
  endtask

  task automatic set_commit(input logic [15:0] pc, input logic rw, input logic [2:0] wreg,
                            input logic [15:0] wdata, input logic mr, input logic mw,
                            input logic [15:0] maddr, input logic [15:0] mdata, input logic halt);
    commit_valid = 1'b1; c_pc = pc; c_regwrite = rw; c_wreg = wreg; c_wdata = wdata;
    c_memread = mr; c_memwrite = mw; c_maddr = maddr; c_mdata = mdata; c_halt = halt;
  endtask

  task automatic end_commit();
    commit_valid = 1'b0; c_regwrite = 1'b0; c_memread = 1'b0; c_memwrite = 1'b0; c_halt = 1'b0;
  endtask

  task automatic do_commit(input logic [15:0] pc, input logic rw, input logic [2:0] wreg,
                           input logic [15:0] wdata, input logic mr, input logic mw,
                           input logic [15:0] maddr, input logic [15:0] mdata, input logic halt);
    set_commit(pc, rw, wreg, wdata, mr, mw, maddr, mdata, halt);
    @(negedge clk);
    end_commit();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Push the three-record golden program REG / ST / HALT.
  task automatic load_program();
    push_one(3'd0, 16'h0000, 3'd3, 16'h1234, 16'h0000, 16'h0000);
    push_one(3'd3, 16'h0002, 3'd0, 16'h0000, 16'h0040, 16'hBEEF);
    push_one(3'd5, 16'h0004, 3'd0, 16'h0000, 16'h0000, 16'h0000);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL reset_exp_ready: got %0b want 0", exp_ready); end
    checks++; if (mismatch !== 1'b0 || underrun !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL reset_flags: got mm=%0b ur=%0b done=%0b pass=%0b want all 0", mismatch, underrun, done, pass); end
    checks++; if (inst_count !== 32'd0 || err_count !== 32'd0 || first_err_inum !== 32'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", inst_count, err_count, first_err_inum); end
    rst = 1'b1;
    #1;
    checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL ready_before_clk: got %0b want 0", exp_ready); end
    @(negedge clk);
    checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL ready_after_clk: got %0b want 1", exp_ready); end
  endtask

  task automatic test_match();
    int mm_seen;
    mm_seen = 0;
    do_reset();
    load_program();
    do_commit(16'h0000, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    if (mismatch !== 1'b0) mm_seen++;
    do_commit(16'h0002, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 1'b0);
    if (mismatch !== 1'b0) mm_seen++;
    do_commit(16'h0004, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    if (mismatch !== 1'b0) mm_seen++;
    checks++; if (mm_seen != 0) begin errors++; $display("FAIL match_no_mismatch: got %0d pulses want 0", mm_seen); end
    checks++; if (inst_count !== 32'd3) begin errors++; $display("FAIL match_inst_count: got %0d want 3", inst_count); end
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL match_done_pass: got done=%0b pass=%0b want 1/1", done, pass); end
    checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL match_ready_in_done: got %0b want 0", exp_ready); end
    checks++; if (pass_n !== 1'b1 || err_count_n !== 32'd0) begin errors++; $display("FAIL match_nostop_pass: got pass=%0b err=%0d want 1/0", pass_n, err_count_n); end
  endtask

  task automatic test_stop_on_err();
    do_reset();
    load_program();
    do_commit(16'h0000, 1'b1, 3'd3, 16'h1235, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL stop_mismatch_pulse: got %0b want 1", mismatch); end
    checks++; if (first_err_inum !== 32'd0 || err_count !== 32'd1) begin errors++; $display("FAIL stop_counts: got first=%0d err=%0d want 0/1", first_err_inum, err_count); end
    checks++; if (exp_ready !== 1'b0 || pass !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stop_fail_state: got ready=%0b pass=%0b done=%0b want 0/0/0", exp_ready, pass, done); end
    @(negedge clk);
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL stop_pulse_width: got %0b want 0", mismatch); end
    do_commit(16'h0002, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 1'b0);
    checks++; if (inst_count !== 32'd1 || mismatch !== 1'b0) begin errors++; $display("FAIL stop_frozen: got inst=%0d mm=%0b want 1/0", inst_count, mismatch); end
    checks++; if (inst_count_n !== 32'd2 || err_count_n !== 32'd1) begin errors++; $display("FAIL nostop_continues: got inst=%0d err=%0d want 2/1", inst_count_n, err_count_n); end
  endtask

  task automatic test_no_stop();
    do_reset();
    load_program();
    do_commit(16'h0000, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    do_commit(16'h0006, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 1'b0);
    checks++; if (mismatch_n !== 1'b1) begin errors++; $display("FAIL nostop_pc_mismatch: got %0b want 1", mismatch_n); end
    do_commit(16'h0004, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    checks++; if (err_count_n !== 32'd1 || first_err_inum_n !== 32'd1) begin errors++; $display("FAIL nostop_counts: got err=%0d first=%0d want 1/1", err_count_n, first_err_inum_n); end
    checks++; if (done_n !== 1'b1 || pass_n !== 1'b0 || inst_count_n !== 32'd3) begin errors++; $display("FAIL nostop_done: got done=%0b pass=%0b inst=%0d want 1/0/3", done_n, pass_n, inst_count_n); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_no_done: got %0b want 0", done); end
  endtask

  task automatic test_underrun();
    do_reset();
    put_exp(3'd0, 16'h0010, 3'd1, 16'h5555, 16'h0000, 16'h0000);
    set_commit(16'h0010, 1'b1, 3'd1, 16'h5555, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    end_commit();
    exp_valid = 1'b0;
    checks++; if (underrun_n !== 1'b1 || mismatch_n !== 1'b1 || err_count_n !== 32'd1) begin errors++; $display("FAIL underrun_flags: got ur=%0b mm=%0b err=%0d want 1/1/1", underrun_n, mismatch_n, err_count_n); end
    checks++; if (underrun !== 1'b1 || first_err_inum_n !== 32'd0) begin errors++; $display("FAIL underrun_stop_first: got ur=%0b first=%0d want 1/0", underrun, first_err_inum_n); end
    do_commit(16'h0010, 1'b1, 3'd1, 16'h5555, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    checks++; if (mismatch_n !== 1'b0 || err_count_n !== 32'd1) begin errors++; $display("FAIL underrun_record_kept: got mm=%0b err=%0d want 0/1", mismatch_n, err_count_n); end
    checks++; if (underrun_n !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %0b want 1", underrun_n); end
  endtask

  task automatic test_wrap();
    int mm_seen;
    int rdy_bad;
    mm_seen = 0;
    rdy_bad = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      put_exp(3'd0, 16'(2 * i), 3'(i), 16'(16'h0100 + i), 16'h0000, 16'h0000);
      @(negedge clk);
    end
    checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL wrap_full_ready: got %0b want 0", exp_ready); end
    // Record 4 stays offered while record 0 pops; the push is refused because the FIFO is full.
    put_exp(3'd0, 16'd8, 3'd4, 16'h0104, 16'h0000, 16'h0000);
    set_commit(16'd0, 1'b1, 3'd0, 16'h0100, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    end_commit();
    if (mismatch !== 1'b0) mm_seen++;
    checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready_after_pop: got %0b want 1", exp_ready); end
    for (int i = 1; i <= 4; i++) begin
      put_exp(3'd0, 16'(2 * (i + 3)), 3'(i + 3), 16'(16'h0100 + i + 3), 16'h0000, 16'h0000);
      set_commit(16'(2 * i), 1'b1, 3'(i), 16'(16'h0100 + i), 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      @(negedge clk);
      end_commit();
      if (mismatch !== 1'b0) mm_seen++;
      if (exp_ready !== 1'b1) rdy_bad++;
    end
    exp_valid = 1'b0;
    for (int i = 5; i < 8; i++) begin
      do_commit(16'(2 * i), 1'b1, 3'(i), 16'(16'h0100 + i), 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      if (mismatch !== 1'b0) mm_seen++;
    end
    checks++; if (mm_seen != 0) begin errors++; $display("FAIL wrap_order: got %0d mismatches want 0", mm_seen); end
    checks++; if (rdy_bad != 0) begin errors++; $display("FAIL wrap_steady_ready: got %0d low cycles want 0", rdy_bad); end
    checks++; if (inst_count !== 32'd8 || err_count !== 32'd0 || underrun !== 1'b0) begin errors++; $display("FAIL wrap_counts: got inst=%0d err=%0d ur=%0b want 8/0/0", inst_count, err_count, underrun); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) push_one(3'd0, 16'(2 * i), 3'(i), 16'(16'h0100 + i), 16'h0000, 16'h0000);
    do_commit(16'd0, 1'b1, 3'd0, 16'h0100, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    checks++; if (inst_count !== 32'd1) begin errors++; $display("FAIL areset_pre_count: got %0d want 1", inst_count); end
    #3;
    rst = 1'b0;
    #1;
    checks++; if (inst_count !== 32'd0 || exp_ready !== 1'b0 || mismatch !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL areset_immediate: got inst=%0d ready=%0b mm=%0b done=%0b want 0/0/0/0", inst_count, exp_ready, mismatch, done); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %0b want 1", exp_ready); end
    do_commit(16'd2, 1'b1, 3'd1, 16'h0101, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    checks++; if (underrun !== 1'b1 || mismatch !== 1'b1) begin errors++; $display("FAIL areset_fifo_flushed: got ur=%0b mm=%0b want 1/1", underrun, mismatch); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_stop_on_err();
    test_no_stop();
    test_underrun();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
